// File: rtl/sar_search.sv
// sar_search: MSB-first successive-approximation controller driving a comparator.
// Optional early exit on cmp_eq when SAR_EARLY_EXIT_EN is defined.
module sar_search #(
  parameter int N = 8,
  localparam int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          cmp_eq,
  input  logic          cmp_lt,
  output logic [N-1:0]  guess,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  result,
  output logic [CW-1:0] probe_cnt
);

  localparam int KW = $clog2(N);

  typedef enum logic {
    IDLE,
    PROBE
  } state_t;

  state_t        state, state_n;
  logic [KW-1:0] k, k_n;
  logic [N-1:0]  guess_n, result_n;
  logic [CW-1:0] cnt_n;
  logic          done_n;
  logic [N-1:0]  bit_k, bit_next, decided;
  logic          hit;

`ifdef SAR_EARLY_EXIT_EN
  assign hit = cmp_eq;
`else
  logic unused_eq;
  assign unused_eq = cmp_eq;
  assign hit = 1'b0;
`endif

  assign bit_k    = N'(1) << k;
  assign bit_next = bit_k >> 1;
  assign decided  = cmp_lt ? (guess & ~bit_k) : guess;
  assign busy     = (state == PROBE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      guess     <= '0;
      k         <= '0;
      done      <= 1'b0;
      result    <= '0;
      probe_cnt <= '0;
    end else begin
      state     <= state_n;
      guess     <= guess_n;
      k         <= k_n;
      done      <= done_n;
      result    <= result_n;
      probe_cnt <= cnt_n;
    end
  end

  always_comb begin
    state_n  = state;
    guess_n  = guess;
    k_n      = k;
    cnt_n    = probe_cnt;
    result_n = result;
    done_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          guess_n = {1'b1, {(N-1){1'b0}}};
          k_n     = KW'(N - 1);
          cnt_n   = '0;
          state_n = PROBE;
        end
      end
      PROBE: begin
        cnt_n = probe_cnt + 1'b1;
        // a hit means guess already equals the target
        if (hit) begin
          result_n = guess;
          guess_n  = '0;
          done_n   = 1'b1;
          state_n  = IDLE;
        end else if (k != '0) begin
          guess_n = decided | bit_next;
          k_n     = k - 1'b1;
        end else begin
          result_n = decided;
          guess_n  = '0;
          done_n   = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sar_search.sv
// tb_sar_search: random and directed searches against an arithmetic SAR model.
// Comparator is modelled combinationally from the bench-held target.
module tb_sar_search;

  localparam int N  = 8;
  localparam int CW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          cmp_eq, cmp_lt;
  logic [N-1:0]  guess, result, target;
  logic          busy, done;
  logic [CW-1:0] probe_cnt;

  int n_checks = 0;
  int n_errs   = 0;

  int exp_g[$];
  int exp_res;
  int exp_cnt;

  sar_search #(.N(N)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .cmp_eq(cmp_eq),
    .cmp_lt(cmp_lt),
    .guess(guess),
    .busy(busy),
    .done(done),
    .result(result),
    .probe_cnt(probe_cnt)
  );

  assign cmp_eq = (guess == target);
  assign cmp_lt = (target < guess);

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Build the answer bit by bit: keep a trial bit when target >= trial.
  task automatic model(input int t);
    int acc;
    int trial;
    exp_g.delete();
    acc = 0;
    for (int i = N - 1; i >= 0; i--) begin
      trial = acc | (1 << i);
      exp_g.push_back(trial);
`ifdef SAR_EARLY_EXIT_EN
      if (trial == t) begin
        acc = trial;
        break;
      end
`endif
      if (t >= trial) acc = trial;
    end
    exp_res = acc;
    exp_cnt = exp_g.size();
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  // Called just after the accepting edge; ends in the done cycle.
  task automatic follow(input int t, input int old_res);
    model(t);
    check("busy_start", busy, 1);
    check("done_start", done, 0);
    for (int i = 0; i < exp_cnt; i++) begin
      check("guess", guess, exp_g[i]);
      check("busy", busy, 1);
      check("result_hold", result, old_res);
      cycle();
    end
    check("done", done, 1);
    check("result", result, exp_res);
    check("probe_cnt", probe_cnt, exp_cnt);
    check("busy_end", busy, 0);
    check("guess_end", guess, 0);
  endtask

  task automatic search(input int t);
    int old_res;
    old_res = result;
    target = N'(t);
    issue_start();
    follow(t, old_res);
    cycle();
    check("done_pulse", done, 0);
    check("result_kept", result, t);
  endtask

  initial begin
    int t1, t2;
    target = '0;
    #3;
    check("rst_guess", guess, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_cnt", probe_cnt, 0);
    #4 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      check("idle_guess", guess, 0);
    end

    search('hA5);
    search('h00);
    search('hFF);
    search('h80);
    search('h40);
    search('h01);
    for (int i = 0; i < 20; i++) search(int'($urandom_range(0, (1 << N) - 1)));

    // start held high: one search, then back-to-back restart in done cycle
    t1 = 'h3C;
    t2 = 'hC3;
    target = N'(t1);
    start = 1'b1;
    t1 = t1;
    begin
      int old_res;
      old_res = result;
      cycle();
      follow(t1, old_res);
    end
    target = N'(t2);
    cycle();
    start = 1'b0;
    follow(t2, t1);
    cycle();
    check("b2b_done_pulse", done, 0);

    // asynchronous abort during probe 4
    target = 'h5A;
    issue_start();
    for (int i = 0; i < 3; i++) cycle();
    check("pre_abort_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_guess", guess, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_result", result, 0);
    check("abort_cnt", probe_cnt, 0);
    cycle();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("post_abort_done", done, 0);
    end
    search('h5A);
    search('hE7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
